vga_sprite_engine: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 39 +++
 rtl/vga_timing_gen.sv | 75 +++++++
 rtl/vga_sprite_engine.sv | 193 +++++++++++++++++++
 tb/tb_vga_sprite_engine.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, pixel tag record and colour-index expansion
// used by the timing generator and the sprite engine.
package vga_timing_pkg;

    // Default 800x600 @ 60 Hz timing for a 40 MHz pixel clock
    localparam int H_PIXELS_DEF   = 800;
    localparam int H_FRONT_DEF    = 40;
    localparam int H_BACK_DEF     = 88;
    localparam int H_SYNCTIME_DEF = 128;
    localparam int V_LINES_DEF    = 600;
    localparam int V_FRONT_DEF    = 1;
    localparam int V_BACK_DEF     = 23;
    localparam int V_SYNCTIME_DEF = 4;

    // RGB12 layout: {r[3:0], g[3:0], b[3:0]}
    localparam int RGB_CH_W = 4;
    localparam int RGB_W    = 3 * RGB_CH_W;

    // Per-pixel tag carried alongside the ROM access so sync and colour stay aligned
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic hit;
        logic fs;
    } pix_tag_t;

    // Total clocks (or lines) in one period of a timing axis
    function automatic int timing_period(input int active, input int front,
                                         input int back, input int sync);
        return active + front + back + sync;
    endfunction

    // Each index bit drives one full colour channel: bit2 -> R, bit1 -> G, bit0 -> B
    function automatic logic [RGB_W-1:0] idx_to_rgb12(input logic [2:0] idx);
        return {{RGB_CH_W{idx[2]}}, {RGB_CH_W{idx[1]}}, {RGB_CH_W{idx[0]}}};
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical counters with raw (undelayed) sync, active-area and
// pixel-coordinate decode. Counter order per line: sync, back porch,
// visible, front porch.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_PIXELS   = H_PIXELS_DEF,
    parameter int H_FRONT    = H_FRONT_DEF,
    parameter int H_BACK     = H_BACK_DEF,
    parameter int H_SYNCTIME = H_SYNCTIME_DEF,
    parameter int V_LINES    = V_LINES_DEF,
    parameter int V_FRONT    = V_FRONT_DEF,
    parameter int V_BACK     = V_BACK_DEF,
    parameter int V_SYNCTIME = V_SYNCTIME_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic [10:0] px,
    output logic [9:0]  py,
    output logic        line_start,
    output logic        frame_start
);

    localparam int H_PERIOD = timing_period(H_PIXELS, H_FRONT, H_BACK, H_SYNCTIME);
    localparam int V_PERIOD = timing_period(V_LINES, V_FRONT, V_BACK, V_SYNCTIME);

    localparam logic [11:0] H_LAST      = 12'(H_PERIOD - 1);
    localparam logic [11:0] H_SYNC_END  = 12'(H_SYNCTIME);
    localparam logic [11:0] H_ACT_START = 12'(H_SYNCTIME + H_BACK);
    localparam logic [11:0] H_ACT_END   = 12'(H_SYNCTIME + H_BACK + H_PIXELS);
    localparam logic [10:0] V_LAST      = 11'(V_PERIOD - 1);
    localparam logic [10:0] V_SYNC_END  = 11'(V_SYNCTIME);
    localparam logic [10:0] V_ACT_START = 11'(V_SYNCTIME + V_BACK);
    localparam logic [10:0] V_ACT_END   = 11'(V_SYNCTIME + V_BACK + V_LINES);

    logic [11:0] hcnt_q, hcnt_d;
    logic [10:0] vcnt_q, vcnt_d;

    // Next counter values: hcnt wraps every line, vcnt steps on each hcnt wrap
    always_comb begin
        hcnt_d = hcnt_q + 12'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 11'd1;
        end
    end

    // Counter registers, cleared by reset so the next frame starts at (0,0)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    // Raw decode of the current counter position
    always_comb begin
        hs          = (hcnt_q < H_SYNC_END);
        vs          = (vcnt_q < V_SYNC_END);
        de          = (hcnt_q >= H_ACT_START) && (hcnt_q < H_ACT_END) &&
                      (vcnt_q >= V_ACT_START) && (vcnt_q < V_ACT_END);
        px          = 11'(hcnt_q - H_ACT_START);
        py          = 10'(vcnt_q - V_ACT_START);
        line_start  = (hcnt_q == '0);
        frame_start = (hcnt_q == '0) && (vcnt_q == '0);
    end

endmodule

// File: rtl/vga_sprite_engine.sv
// VGA timing plus single-sprite renderer. Sprite position is shadowed once
// per frame; ROM address is built from a row base and a column counter;
// sync and colour leave through a common delay of ROM_LAT+2 clocks.
// Build option VGA_SPR_SCALE2X_EN draws the sprite 2x2 replicated.
// frame_start is the frame's (0,0) marker after the same delay, so it
// coincides with the falling edge of vsyncb.
module vga_sprite_engine
    import vga_timing_pkg::*;
#(
    parameter int H_PIXELS   = H_PIXELS_DEF,
    parameter int H_FRONT    = H_FRONT_DEF,
    parameter int H_BACK     = H_BACK_DEF,
    parameter int H_SYNCTIME = H_SYNCTIME_DEF,
    parameter int V_LINES    = V_LINES_DEF,
    parameter int V_FRONT    = V_FRONT_DEF,
    parameter int V_BACK     = V_BACK_DEF,
    parameter int V_SYNCTIME = V_SYNCTIME_DEF,
    parameter int SPR_W      = 200,
    parameter int SPR_H      = 200,
    parameter int ADDR_W     = 17,
    parameter int IDX_W      = 3,
    parameter int ROM_LAT    = 1
) (
    input  logic              clk_40M,
    input  logic              Reset_n,
    input  logic              spr_en,
    input  logic [10:0]       spr_x,
    input  logic [9:0]        spr_y,
    input  logic [RGB_W-1:0]  bg_color,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_data,
    output logic              hsyncb,
    output logic              vsyncb,
    output logic [RGB_W-1:0]  rgb,
    output logic              frame_start
);

`ifdef VGA_SPR_SCALE2X_EN
    localparam int SCALE = 2;
    logic x_sub_q, x_sub_d;
    logic y_sub_q, y_sub_d;
`else
    localparam int SCALE = 1;
`endif

    localparam logic [11:0]       WIN_W    = 12'(SPR_W * SCALE);
    localparam logic [10:0]       WIN_H    = 11'(SPR_H * SCALE);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SPR_W);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    logic        hs_s0, vs_s0, de_s0, ls_s0, fs_s0, hit_s0;
    logic [10:0] px_s0;
    logic [9:0]  py_s0;

    vga_timing_gen #(
        .H_PIXELS(H_PIXELS), .H_FRONT(H_FRONT), .H_BACK(H_BACK), .H_SYNCTIME(H_SYNCTIME),
        .V_LINES(V_LINES), .V_FRONT(V_FRONT), .V_BACK(V_BACK), .V_SYNCTIME(V_SYNCTIME)
    ) u_timing (
        .clk(clk_40M), .rst_n(Reset_n), .hs(hs_s0), .vs(vs_s0), .de(de_s0),
        .px(px_s0), .py(py_s0), .line_start(ls_s0), .frame_start(fs_s0)
    );

    logic              shd_en_q, shd_en_d;
    logic [10:0]       shd_x_q, shd_x_d;
    logic [9:0]        shd_y_q, shd_y_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              hit_prev_q, hit_prev_d;
    pix_tag_t          tag_q [ROM_LAT+1];
    pix_tag_t          tag_d [ROM_LAT+1];
    pix_tag_t          tag_out;
    logic              hsyncb_q, hsyncb_d, vsyncb_q, vsyncb_d, fs_q, fs_d;
    logic [RGB_W-1:0]  rgb_q, rgb_d;

    // Sprite window test; right/bottom clipping comes from de, no wrap-around
    always_comb begin
        hit_s0 = de_s0 && shd_en_q &&
                 (px_s0 >= shd_x_q) && ({1'b0, px_s0} < ({1'b0, shd_x_q} + WIN_W)) &&
                 (py_s0 >= shd_y_q) && ({1'b0, py_s0} < ({1'b0, shd_y_q} + WIN_H));
    end

    // Frame shadow of the sprite request plus row-base/column address walk
    always_comb begin
        shd_en_d   = shd_en_q;
        shd_x_d    = shd_x_q;
        shd_y_d    = shd_y_q;
        row_base_d = row_base_q;
        col_d      = col_q;
        rom_addr_d = rom_addr_q;
        hit_prev_d = hit_s0;
`ifdef VGA_SPR_SCALE2X_EN
        x_sub_d    = x_sub_q;
        y_sub_d    = y_sub_q;
`endif
        if (ls_s0) begin
            col_d = '0;
`ifdef VGA_SPR_SCALE2X_EN
            x_sub_d = 1'b0;
`endif
        end
        if (hit_s0) begin
            rom_addr_d = row_base_q + col_q;
`ifdef VGA_SPR_SCALE2X_EN
            x_sub_d = ~x_sub_q;
            if (x_sub_q) col_d = col_q + ONE;
`else
            col_d = col_q + ONE;
`endif
        end
        // Falling edge of hit marks the end of a sprite row (including a clipped one)
        if (hit_prev_q && !hit_s0) begin
`ifdef VGA_SPR_SCALE2X_EN
            y_sub_d = ~y_sub_q;
            if (y_sub_q) row_base_d = row_base_q + ROW_STEP;
`else
            row_base_d = row_base_q + ROW_STEP;
`endif
        end
        if (fs_s0) begin
            shd_en_d   = spr_en;
            shd_x_d    = spr_x;
            shd_y_d    = spr_y;
            row_base_d = '0;
`ifdef VGA_SPR_SCALE2X_EN
            y_sub_d    = 1'b0;
`endif
        end
    end

    // Tag delay line: stage 0 enters, tag_q[ROM_LAT] lines up with rom_data
    always_comb begin
        tag_d[0] = '{hs: hs_s0, vs: vs_s0, de: de_s0, hit: hit_s0, fs: fs_s0};
        for (int i = 1; i <= ROM_LAT; i++) tag_d[i] = tag_q[i-1];
        tag_out = tag_q[ROM_LAT];
    end

    // Output stage: colour select and active-low syncs
    always_comb begin
        hsyncb_d = ~tag_out.hs;
        vsyncb_d = ~tag_out.vs;
        fs_d     = tag_out.fs;
        if (tag_out.hit)     rgb_d = idx_to_rgb12(rom_data[2:0]);
        else if (tag_out.de) rgb_d = bg_color;
        else                 rgb_d = '0;
    end

    // All engine state; reset clears every stage and parks syncs inactive
    always_ff @(posedge clk_40M) begin
        if (!Reset_n) begin
            shd_en_q   <= 1'b0;
            shd_x_q    <= '0;
            shd_y_q    <= '0;
            row_base_q <= '0;
            col_q      <= '0;
            rom_addr_q <= '0;
            hit_prev_q <= 1'b0;
`ifdef VGA_SPR_SCALE2X_EN
            x_sub_q    <= 1'b0;
            y_sub_q    <= 1'b0;
`endif
            for (int i = 0; i <= ROM_LAT; i++) tag_q[i] <= '0;
            hsyncb_q   <= 1'b1;
            vsyncb_q   <= 1'b1;
            fs_q       <= 1'b0;
            rgb_q      <= '0;
        end else begin
            shd_en_q   <= shd_en_d;
            shd_x_q    <= shd_x_d;
            shd_y_q    <= shd_y_d;
            row_base_q <= row_base_d;
            col_q      <= col_d;
            rom_addr_q <= rom_addr_d;
            hit_prev_q <= hit_prev_d;
`ifdef VGA_SPR_SCALE2X_EN
            x_sub_q    <= x_sub_d;
            y_sub_q    <= y_sub_d;
`endif
            tag_q      <= tag_d;
            hsyncb_q   <= hsyncb_d;
            vsyncb_q   <= vsyncb_d;
            fs_q       <= fs_d;
            rgb_q      <= rgb_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign hsyncb      = hsyncb_q;
    assign vsyncb      = vsyncb_q;
    assign rgb         = rgb_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Bench for vga_sprite_engine on a shrunken raster (29 x 17 clocks per frame).
// The reference computes every output from the cycle number since reset
// release: raster position by division, sprite hit and ROM address by
// window arithmetic, using the sprite request sampled at each frame start.
module tb_vga_sprite_engine;

    localparam int HPIX = 20, HFP = 2, HBP = 3, HSW = 4;
    localparam int VLIN = 12, VFP = 1, VBP = 2, VSW = 2;
    localparam int SW = 5, SH = 4, AW = 8, IW = 3, RL = 2;
    localparam int D     = RL + 2;
    localparam int HP    = HPIX + HFP + HBP + HSW;
    localparam int VP    = VLIN + VFP + VBP + VSW;
    localparam int FRAME = HP * VP;
    localparam int NF    = 64;
`ifdef VGA_SPR_SCALE2X_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif

    logic          clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          spr_en = 1'b0;
    logic [10:0]   spr_x = '0;
    logic [9:0]    spr_y = '0;
    logic [11:0]   bg_color = '0;
    logic [AW-1:0] rom_addr;
    logic [IW-1:0] rom_data;
    logic          hsyncb, vsyncb, frame_start;
    logic [11:0]   rgb;

    int tests_run = 0;
    int tests_failed = 0;

    // clock / reset block
    always #5 clk = ~clk;

    vga_sprite_engine #(
        .H_PIXELS(HPIX), .H_FRONT(HFP), .H_BACK(HBP), .H_SYNCTIME(HSW),
        .V_LINES(VLIN), .V_FRONT(VFP), .V_BACK(VBP), .V_SYNCTIME(VSW),
        .SPR_W(SW), .SPR_H(SH), .ADDR_W(AW), .IDX_W(IW), .ROM_LAT(RL)
    ) dut (
        .clk_40M(clk), .Reset_n(Reset_n), .spr_en(spr_en), .spr_x(spr_x),
        .spr_y(spr_y), .bg_color(bg_color), .rom_addr(rom_addr),
        .rom_data(rom_data), .hsyncb(hsyncb), .vsyncb(vsyncb), .rgb(rgb),
        .frame_start(frame_start)
    );

    // Artwork ROM: scrambled index per address so wrong addresses show up
    function automatic logic [IW-1:0] rom_fn(input logic [AW-1:0] a);
        int v;
        v = int'(a);
        return IW'((v * 3 + v / 4) % 8);
    endfunction

    function automatic logic [11:0] expand(input logic [IW-1:0] i);
        logic [11:0] c;
        c[11:8] = i[2] ? 4'hF : 4'h0;
        c[7:4]  = i[1] ? 4'hF : 4'h0;
        c[3:0]  = i[0] ? 4'hF : 4'h0;
        return c;
    endfunction

    logic [IW-1:0] rom_pipe [RL];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_fn(rom_addr);
        for (int i = 1; i < RL; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[RL-1];

    // Reference state: cycle number, per-frame sprite request, sampled bg
    int          n = 0;
    bit          running = 1'b0;
    bit          shd_en [NF];
    int          shd_x [NF];
    int          shd_y [NF];
    logic [11:0] bg_cap = '0;

    always @(posedge clk) begin
        bg_cap <= bg_color;
        if (running && (n % FRAME == 0) && (n / FRAME < NF)) begin
            shd_en[n / FRAME] <= spr_en;
            shd_x[n / FRAME]  <= int'(spr_x);
            shd_y[n / FRAME]  <= int'(spr_y);
        end
    end

    logic          exp_hsyncb, exp_vsyncb, exp_fs;
    logic [11:0]   exp_rgb;
    logic [AW-1:0] exp_addr;

    task automatic ref_pixel(input int m, output bit hs, output bit vs, output bit de,
                             output bit hit, output int addr);
        int h, v, f, px, py;
        h  = m % HP;
        v  = (m / HP) % VP;
        f  = m / FRAME;
        hs = (h < HSW);
        vs = (v < VSW);
        px = h - (HSW + HBP);
        py = v - (VSW + VBP);
        de = (px >= 0) && (px < HPIX) && (py >= 0) && (py < VLIN);
        hit = de && (f < NF) && shd_en[f] &&
              (px >= shd_x[f]) && (px < shd_x[f] + S * SW) &&
              (py >= shd_y[f]) && (py < shd_y[f] + S * SH);
        addr = hit ? ((py - shd_y[f]) / S) * SW + (px - shd_x[f]) / S : 0;
    endtask

    // Advance one clock and compute every expected output for it
    task automatic advance();
        bit hs, vs, de, hit;
        int addr, m;
        @(negedge clk);
        n++;
        m = n - 1;
        if (m >= 0) begin
            ref_pixel(m, hs, vs, de, hit, addr);
            if (hit) exp_addr = AW'(addr);
        end
        m = n - D;
        if (m < 0) begin
            exp_hsyncb = 1'b1; exp_vsyncb = 1'b1; exp_fs = 1'b0; exp_rgb = '0;
        end else begin
            ref_pixel(m, hs, vs, de, hit, addr);
            exp_hsyncb = !hs;
            exp_vsyncb = !vs;
            exp_fs     = (m % FRAME == 0);
            if (hit)     exp_rgb = expand(rom_fn(AW'(addr)));
            else if (de) exp_rgb = bg_cap;
            else         exp_rgb = '0;
        end
    endtask

    // driver: release reset; the cycle following is raster position (0,0)
    task automatic release_reset();
        @(negedge clk);
        Reset_n  = 1'b1;
        n        = 0;
        running  = 1'b1;
        exp_addr = '0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run += 5;
            if (hsyncb !== 1'b1) begin tests_failed++; $display("FAIL reset_hsyncb got %b want 1", hsyncb); end
            if (vsyncb !== 1'b1) begin tests_failed++; $display("FAIL reset_vsyncb got %b want 1", vsyncb); end
            if (rgb !== 12'h000) begin tests_failed++; $display("FAIL reset_rgb got %h want 000", rgb); end
            if (rom_addr !== '0) begin tests_failed++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
            if (frame_start !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_start got %b want 0", frame_start); end
        end
    endtask

    task automatic test_sync_timing();
        int hlow = 0, vlow = 0, fcnt = 0;
        spr_en = 1'b0;
        bg_color = 12'($urandom);
        release_reset();
        for (int i = 0; i < FRAME + D + 5; i++) begin
            advance();
            if (n >= D && n < D + FRAME) begin
                hlow += (hsyncb == 1'b0) ? 1 : 0;
                vlow += (vsyncb == 1'b0) ? 1 : 0;
                fcnt += (frame_start == 1'b1) ? 1 : 0;
            end
            tests_run += 4;
            if (hsyncb !== exp_hsyncb) begin tests_failed++; $display("FAIL sync_hsyncb n=%0d got %b want %b", n, hsyncb, exp_hsyncb); end
            if (vsyncb !== exp_vsyncb) begin tests_failed++; $display("FAIL sync_vsyncb n=%0d got %b want %b", n, vsyncb, exp_vsyncb); end
            if (frame_start !== exp_fs) begin tests_failed++; $display("FAIL sync_frame_start n=%0d got %b want %b", n, frame_start, exp_fs); end
            if (rgb !== exp_rgb) begin tests_failed++; $display("FAIL sync_bg_rgb n=%0d got %h want %h", n, rgb, exp_rgb); end
        end
        tests_run += 3;
        if (hlow != HSW * VP) begin tests_failed++; $display("FAIL sync_hlow_count got %0d want %0d", hlow, HSW * VP); end
        if (vlow != VSW * HP) begin tests_failed++; $display("FAIL sync_vlow_count got %0d want %0d", vlow, VSW * HP); end
        if (fcnt != 1) begin tests_failed++; $display("FAIL sync_frame_pulses got %0d want 1", fcnt); end
    endtask

    // Sprite picture test; runs until the requested cycle number
    task automatic test_sprite_basic();
        spr_en = 1'b1; spr_x = 11'd3; spr_y = 10'd2;
        bg_color = 12'h5A3;
        while (n < 3 * FRAME + D + 1) begin
            advance();
            tests_run += 3;
            if (rgb !== exp_rgb) begin tests_failed++; $display("FAIL basic_rgb n=%0d got %h want %h", n, rgb, exp_rgb); end
            if (rom_addr !== exp_addr) begin tests_failed++; $display("FAIL basic_rom_addr n=%0d got %0d want %0d", n, rom_addr, exp_addr); end
            if (hsyncb !== exp_hsyncb) begin tests_failed++; $display("FAIL basic_hsyncb n=%0d got %b want %b", n, hsyncb, exp_hsyncb); end
        end
    endtask

    task automatic test_midframe_move();
        int stop;
        stop = (n / FRAME + 2) * FRAME + D + 1;
        while (n < stop) begin
            advance();
            if (n % FRAME == FRAME / 2) spr_x = 11'd12;
            tests_run += 2;
            if (rgb !== exp_rgb) begin tests_failed++; $display("FAIL move_rgb n=%0d got %h want %h", n, rgb, exp_rgb); end
            if (rom_addr !== exp_addr) begin tests_failed++; $display("FAIL move_rom_addr n=%0d got %0d want %0d", n, rom_addr, exp_addr); end
        end
    endtask

    task automatic test_clip();
        int stop;
        spr_en = 1'b1; spr_x = 11'(HPIX - 2); spr_y = 10'(VLIN - 2);
        stop = (n / FRAME + 2) * FRAME + D + 1;
        while (n < stop) begin
            advance();
            tests_run += 2;
            if (rgb !== exp_rgb) begin tests_failed++; $display("FAIL clip_rgb n=%0d got %h want %h", n, rgb, exp_rgb); end
            if (rom_addr !== exp_addr) begin tests_failed++; $display("FAIL clip_rom_addr n=%0d got %0d want %0d", n, rom_addr, exp_addr); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4 * FRAME; i++) begin
            advance();
            tests_run += 5;
            if (rgb !== exp_rgb) begin tests_failed++; $display("FAIL rand_rgb n=%0d got %h want %h", n, rgb, exp_rgb); end
            if (rom_addr !== exp_addr) begin tests_failed++; $display("FAIL rand_rom_addr n=%0d got %0d want %0d", n, rom_addr, exp_addr); end
            if (hsyncb !== exp_hsyncb) begin tests_failed++; $display("FAIL rand_hsyncb n=%0d got %b want %b", n, hsyncb, exp_hsyncb); end
            if (vsyncb !== exp_vsyncb) begin tests_failed++; $display("FAIL rand_vsyncb n=%0d got %b want %b", n, vsyncb, exp_vsyncb); end
            if (frame_start !== exp_fs) begin tests_failed++; $display("FAIL rand_frame_start n=%0d got %b want %b", n, frame_start, exp_fs); end
            if ($urandom_range(0, 39) == 0) begin
                spr_en = 1'($urandom_range(0, 1));
                spr_x  = 11'($urandom_range(0, HPIX + 2));
                spr_y  = 10'($urandom_range(0, VLIN + 1));
            end
            if ($urandom_range(0, 59) == 0) bg_color = 12'($urandom);
        end
    endtask

    task automatic test_reset_midframe();
        int guard = 0;
        while ((n % FRAME) != (FRAME / 2) && guard < 2 * FRAME) begin
            advance();
            guard++;
        end
        tests_run++;
        if ((n % FRAME) != (FRAME / 2)) begin tests_failed++; $display("FAIL midreset_reach n=%0d got %0d want %0d", n, n % FRAME, FRAME / 2); end
        Reset_n = 1'b0;
        running = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run += 4;
            if (hsyncb !== 1'b1) begin tests_failed++; $display("FAIL midreset_hsyncb got %b want 1", hsyncb); end
            if (vsyncb !== 1'b1) begin tests_failed++; $display("FAIL midreset_vsyncb got %b want 1", vsyncb); end
            if (rgb !== 12'h000) begin tests_failed++; $display("FAIL midreset_rgb got %h want 000", rgb); end
            if (rom_addr !== '0) begin tests_failed++; $display("FAIL midreset_rom_addr got %0d want 0", rom_addr); end
        end
        spr_en = 1'b1; spr_x = 11'd7; spr_y = 10'd5;
        bg_color = 12'h1C9;
        release_reset();
        for (int i = 0; i < FRAME + D + 10; i++) begin
            advance();
            tests_run += 5;
            if (rgb !== exp_rgb) begin tests_failed++; $display("FAIL midreset_post_rgb n=%0d got %h want %h", n, rgb, exp_rgb); end
            if (rom_addr !== exp_addr) begin tests_failed++; $display("FAIL midreset_post_rom_addr n=%0d got %0d want %0d", n, rom_addr, exp_addr); end
            if (hsyncb !== exp_hsyncb) begin tests_failed++; $display("FAIL midreset_post_hsyncb n=%0d got %b want %b", n, hsyncb, exp_hsyncb); end
            if (vsyncb !== exp_vsyncb) begin tests_failed++; $display("FAIL midreset_post_vsyncb n=%0d got %b want %b", n, vsyncb, exp_vsyncb); end
            if (frame_start !== exp_fs) begin tests_failed++; $display("FAIL midreset_post_frame_start n=%0d got %b want %b", n, frame_start, exp_fs); end
        end
    endtask

    initial begin
        test_reset();
        test_sync_timing();
        test_sprite_basic();
        test_midframe_move();
        test_clip();
        test_random();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
